// File: rtl/sub_cells_inv_iter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sbox
//   Nibble-sliced m-bit S-box cell (m a multiple of 4), built from a 4-bit
//   QARMA sigma table.
//   Forward: each input nibble j goes through the 4-bit table and lands in
//   nibble (j+1) mod (m/4).
//   Inverse: the nibble rotation is undone first, then the inverse table is
//   applied.
//   sigma[1:0] selects the 4-bit table (0: sigma0, 1: sigma1, 2/3: sigma2).
//   Ports:
//     x  m-bit input cell
//     y  m-bit substituted cell
// -----------------------------------------------------------------------------
module sbox #(
  parameter int          m     = 8,
  parameter logic [63:0] sigma = 64'b0,
  parameter bit          inv   = 1'b0
) (
  input  logic [m-1:0] x,
  output logic [m-1:0] y
);
  localparam int NIB = m / 4;

  // 4-bit tables; entry v sits at bits [4v +: 4].
  localparam logic [63:0] T0 = 64'h51cd7346b8f9a2e0;
  localparam logic [63:0] T1 = 64'h421bc089537f6eda;
  localparam logic [63:0] T2 = 64'ha12d5473e90cf86b;

  // Table inversion, evaluated at elaboration time only.
  function automatic logic [63:0] invert(input logic [63:0] t);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[{t[i*4 +: 4], 2'b00} +: 4] = 4'(i);
    return r;
  endfunction

  localparam logic [63:0] FWD = (sigma[1:0] == 2'd0) ? T0 :
                                (sigma[1:0] == 2'd1) ? T1 : T2;
  localparam logic [63:0] REV = invert(FWD);

  if ((m % 4) != 0 || m < 4) begin : g_bad_m
    $error("sbox: m must be a non-zero multiple of 4");
  end

  for (genvar j = 0; j < NIB; j++) begin : g_nib
    if (inv) begin : g_inv
      assign y[j*4 +: 4] = REV[{x[((j+1)%NIB)*4 +: 4], 2'b00} +: 4];
    end else begin : g_fwd
      assign y[((j+1)%NIB)*4 +: 4] = FWD[{x[j*4 +: 4], 2'b00} +: 4];
    end
  end
endmodule

// -----------------------------------------------------------------------------
// sub_cells_inv_iter
//   Iterative inverse SubCells for the QARMA-128 decrypt datapath.
//   CPC cells of the 16-cell state are inverse-substituted per clock, in place,
//   in a work register. A full state therefore takes 16/CPC cycles.
//   Handshake:
//     IDLE accepts a state.
//     RUN walks the cell groups.
//     DONE presents the result until it is taken.
//   Input and output transfers never overlap.
//   Ports:
//     clk, rst    clock / asynchronous active-high reset
//     in_valid    in_data is valid
//     in_ready    block can accept a state (IDLE)
//     in_data     n-bit state; cell i = in_data[i*m +: m]
//     out_valid   out_data holds a completed result (DONE)
//     out_ready   downstream takes the result
//     out_data    result; always the work register
//     busy        high while cell groups are being processed (RUN)
// -----------------------------------------------------------------------------
module sub_cells_inv_iter #(
  parameter int          n     = 128,
  parameter logic [63:0] sigma = 64'b0,
  parameter int          CPC   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         busy
);
  localparam int m      = n / 16;
  localparam int GROUPS = 16 / CPC;
  localparam int KW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [KW-1:0] LAST = KW'(GROUPS - 1);

  if (!(CPC == 1 || CPC == 2 || CPC == 4 || CPC == 8 || CPC == 16)) begin : g_bad_cpc
    $error("sub_cells_inv_iter: CPC must be 1, 2, 4, 8 or 16");
  end
  if ((n % 16) != 0) begin : g_bad_n
    $error("sub_cells_inv_iter: n must be a multiple of 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k;
  logic [n-1:0]      w;
  logic [n-1:0]      w_nxt;
  logic              load, step;

  logic [CPC-1:0][m-1:0] grp_in;
  logic [CPC-1:0][m-1:0] grp_out;

  // Current group: cells k*CPC .. k*CPC+CPC-1 of the work register.
  for (genvar c = 0; c < CPC; c++) begin : g_lane
    assign grp_in[c] = w[(int'(k)*CPC + c)*m +: m];

    sbox #(.m(m), .sigma(sigma), .inv(1'b1)) u_sbox (
      .x (grp_in[c]),
      .y (grp_out[c])
    );
  end

  // In-place update: only cells belonging to group k take the S-box output.
  for (genvar i = 0; i < 16; i++) begin : g_cell
    assign w_nxt[i*m +: m] = (k == KW'(i / CPC)) ? grp_out[i % CPC] : w[i*m +: m];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (k == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k       <= '0;
      w       <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        w <= in_data;
        k <= '0;
      end else if (step) begin
        w <= w_nxt;
        // Counter wraps on the final group so it is 0 again on leaving RUN.
        k <= (k == LAST) ? '0 : k + 1'b1;
      end
    end
  end

  assign out_data = w;
endmodule

// File: tb/tb_sub_cells_inv_iter.sv
`timescale 1ns/1ps
// Bench for sub_cells_inv_iter: five instances (CPC = 1,2,4,8,16) sharing clock
// and reset, checked against a byte-level inverse S-box table derived by
// exhaustive search over the forward S-box.
module tb_sub_cells_inv_iter;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic iv[5], ir[5], ov[5], ordy[5], bsy[5];
  logic [127:0] id[5], od[5];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_cells_inv_iter #(.n(128), .sigma(64'd1), .CPC(1 << g)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]),
      .busy(bsy[g])
    );
  end

  always #5 if (clk_en) clk = ~clk;

  // ---------------- reference model ----------------
  // sigma1 4-bit table; the 8-bit cell is {S(lo), S(hi)}.
  int s4[16] = '{10, 13, 14, 6, 15, 7, 3, 5, 9, 8, 0, 12, 11, 1, 2, 4};
  logic [7:0] inv8[256];

  function automatic logic [7:0] fwd8(input logic [7:0] b);
    return 8'(s4[b % 16] * 16 + s4[b / 16]);
  endfunction

  function automatic logic [127:0] fwd_sc(input logic [127:0] p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd8(p[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_sc(input logic [127:0] p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv8[p[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // One transfer with out_ready held high; returns result, latency in cycles
  // from the accept edge to out_valid, and number of cycles busy was seen.
  task automatic xfer(input int d, input logic [127:0] din,
                      output logic [127:0] dout, output int lat, output int bc);
    int wt;
    wt = 0;
    @(negedge clk);
    iv[d] = 1'b1; id[d] = din; ordy[d] = 1'b1;
    #1;
    while (!ir[d] && wt < 50) begin @(negedge clk); #1; wt++; end
    if (wt >= 50) fail("accept_timeout");
    @(posedge clk);
    #1 iv[d] = 1'b0;
    lat = 0; bc = 0;
    @(negedge clk);
    while (!ov[d] && lat < 40) begin
      if (bsy[d]) bc++;
      lat++;
      @(negedge clk);
    end
    dout = od[d];
    @(posedge clk);
  endtask

  // Random valid/ready traffic against a queue scoreboard.
  task automatic rand_run(input int d, input int nst, input int budget);
    logic [127:0] q[$];
    logic [127:0] e;
    int got, sent, cyc;
    got = 0; sent = 0; cyc = 0;
    while (got < nst && cyc < budget) begin
      @(negedge clk);
      cyc++;
      iv[d]   = ($urandom_range(0, 9) < 7) && (sent < nst);
      id[d]   = rnd128();
      ordy[d] = ($urandom_range(0, 9) < 7);
      #1;
      if (ir[d] && ov[d]) fail("rand_overlap");
      if (iv[d] && ir[d]) begin
        q.push_back(inv_sc(id[d]));
        sent++;
      end
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) fail("rand_spurious_output");
        else begin
          e = q.pop_front();
          check("rand_data", od[d], e);
          got++;
        end
      end
    end
    @(negedge clk);
    iv[d] = 1'b0; ordy[d] = 1'b1;
    check("rand_count", 128'(got), 128'(nst));
    check("rand_pending", 128'(q.size()), 128'd0);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    logic [127:0] dout, p, a, b;
    int lat, bc, wt, pulses;

    for (int x = 0; x < 256; x++) inv8[fwd8(8'(x))] = 8'(x);
    for (int d = 0; d < 5; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0;
    end

    vt[0].exp = 128'h0123456789abcdeffedcba9876543210; vt[0].din = fwd_sc(vt[0].exp);
    vt[1].din = '0;                                    vt[1].exp = {16{8'haa}};
    vt[2].exp = '1;                                    vt[2].din = fwd_sc(vt[2].exp);
    vt[3].exp = rnd128();                              vt[3].din = fwd_sc(vt[3].exp);

    // Asynchronous reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 5; d++) begin
      check("rst_in_ready", 128'(ir[d]), 128'd1);
      check("rst_out_valid", 128'(ov[d]), 128'd0);
      check("rst_busy", 128'(bsy[d]), 128'd0);
      check("rst_out_data", od[d], 128'd0);
    end
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Vector table across all CPC values.
    for (int v = 0; v < 4; v++) begin
      for (int d = 0; d < 5; d++) begin
        xfer(d, vt[v].din, dout, lat, bc);
        check($sformatf("vec%0d_cpc%0d_data", v, 1 << d), dout, vt[v].exp);
        check($sformatf("vec%0d_cpc%0d_latency", v, 1 << d), 128'(lat), 128'(16 >> d));
        check($sformatf("vec%0d_cpc%0d_busy", v, 1 << d), 128'(bc), 128'(16 >> d));
      end
    end

    // Backpressure on CPC=4 with a second state waiting on in_valid.
    p = rnd128(); a = fwd_sc(p); b = rnd128();
    @(negedge clk);
    iv[2] = 1'b1; id[2] = a; ordy[2] = 1'b0;
    @(posedge clk);
    #1 id[2] = b;
    wt = 0;
    @(negedge clk);
    while (!ov[2] && wt < 40) begin @(negedge clk); wt++; end
    check("bp_first_data", od[2], p);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_data", od[2], p);
      check("bp_hold_valid", 128'(ov[2]), 128'd1);
      check("bp_in_ready", 128'(ir[2]), 128'd0);
    end
    ordy[2] = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 128'(ir[2]), 128'd1);
    check("bp_idle_busy", 128'(bsy[2]), 128'd0);
    check("bp_idle_valid", 128'(ov[2]), 128'd0);
    @(negedge clk);
    check("bp_second_accepted", 128'(bsy[2]), 128'd1);
    iv[2] = 1'b0;
    wt = 0;
    while (!ov[2] && wt < 40) begin @(negedge clk); wt++; end
    check("bp_second_data", od[2], inv_sc(b));
    @(posedge clk);

    // Reset in the middle of RUN (k = 2, CPC=4).
    @(negedge clk);
    iv[2] = 1'b1; id[2] = rnd128(); ordy[2] = 1'b1;
    @(posedge clk);
    #1 iv[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(ov[2]), 128'd0);
    check("midrst_in_ready", 128'(ir[2]), 128'd1);
    check("midrst_busy", 128'(bsy[2]), 128'd0);
    check("midrst_out_data", od[2], 128'd0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (ov[2]) pulses++; end
    check("midrst_no_pulse", 128'(pulses), 128'd0);
    xfer(2, 128'd0, dout, lat, bc);
    check("midrst_zero_data", dout, inv_sc(128'd0));
    check("midrst_zero_const", dout, {16{8'haa}});

    // Random regression.
    rand_run(2, 1500, 60000);
    for (int d = 0; d < 5; d++) if (d != 2) rand_run(d, 150, 8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
